aes_kat_sequencer: RTL and testbench

Known-answer-test (KAT) controller that sits directly upstream of the SPI master / AES engine path and consumes its results. It presents a FIPS-197 Appendix C plaintext/key pair for the selected key size and requests an encryption. It checks the ciphertext, feeds that ciphertext back for decryption, then checks the recovered plaintext. Pass/fail flags are registered for the top-level self-test.

---
 rtl/aes_kat_pkg.sv | 30 +++
 rtl/aes_kat_rom.sv | 34 +++
 rtl/aes_kat_sequencer.sv | 179 +++++++++++++++++
 tb/tb_aes_kat_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_kat_pkg.sv
// rtl/aes_kat_pkg.sv - FIPS-197 Appendix C vectors, key-size codes and FSM encoding for the KAT sequencer
package aes_kat_pkg;

    localparam logic [1:0] NK4    = 2'b00;
    localparam logic [1:0] NK6    = 2'b01;
    localparam logic [1:0] NK8    = 2'b10;
    localparam logic [1:0] NK_BAD = 2'b11;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_ENC_REQ  = 3'd2;
    localparam logic [2:0] ST_ENC_WAIT = 3'd3;
    localparam logic [2:0] ST_DEC_REQ  = 3'd4;
    localparam logic [2:0] ST_DEC_WAIT = 3'd5;
    localparam logic [2:0] ST_FINISH   = 3'd6;
    localparam logic [2:0] ST_ERR      = 3'd7;

    localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;

    localparam logic [127:0] KAT_KEY_128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] KAT_KEY_192 =
        192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] KAT_KEY_256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    localparam logic [127:0] KAT_CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KAT_CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] KAT_CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

endpackage

// File: rtl/aes_kat_rom.sv
// rtl/aes_kat_rom.sv - combinational lookup of the known-answer key and ciphertext for a key size
module aes_kat_rom
    import aes_kat_pkg::*;
(
    input  logic [1:0]   nk_i,
    output logic [255:0] key_o,
    output logic [127:0] ct_o
);

    // Keys are left-justified so the engine always reads the first key byte from bit 255.
    always_comb begin
        key_o = '0;
        ct_o  = '0;
        case (nk_i)
            NK4: begin
                key_o = {KAT_KEY_128, 128'h0};
                ct_o  = KAT_CT_128;
            end
            NK6: begin
                key_o = {KAT_KEY_192, 64'h0};
                ct_o  = KAT_CT_192;
            end
            NK8: begin
                key_o = KAT_KEY_256;
                ct_o  = KAT_CT_256;
            end
            default: begin
                key_o = '0;
                ct_o  = '0;
            end
        endcase
    end

endmodule

// File: rtl/aes_kat_sequencer.sv
// rtl/aes_kat_sequencer.sv - AES encrypt/decrypt known-answer-test sequencer
// Define AES_KAT_SWEEP_EN to run Nk4, Nk6 and Nk8 back-to-back on a single go.
module aes_kat_sequencer
    import aes_kat_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         go,
    input  logic [1:0]   nk_sel,
    output logic [1:0]   nk_val,
    output logic [127:0] data_in,
    output logic [255:0] key_in,
    output logic         start_enc,
    output logic         start_dec,
    input  logic         done_enc,
    input  logic         done_dec,
    input  logic [127:0] data_out,
    output logic         busy,
    output logic         pass_enc,
    output logic         pass_dec,
    output logic         done,
    output logic         timeout_err
);

`ifdef AES_KAT_SWEEP_EN
    localparam bit SWEEP = 1'b1;
    logic unused_nk_sel;
    assign unused_nk_sel = ^nk_sel;
`else
    localparam bit SWEEP = 1'b0;
`endif

    // Leaving WAIT as the counter steps onto TIMEOUT_CYCLES-1 puts done exactly TIMEOUT_CYCLES after start.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       nk_val_q, nk_val_d;
    logic [127:0]     data_in_q, data_in_d;
    logic [255:0]     key_in_q, key_in_d;
    logic             pass_enc_q, pass_enc_d;
    logic             pass_dec_q, pass_dec_d;
    logic             timeout_err_q, timeout_err_d;

    logic [255:0]     rom_key;
    logic [127:0]     rom_ct;
    logic             enc_match;
    logic             dec_match;
    logic             accumulate;
    logic             last_size;

    aes_kat_rom u_rom (
        .nk_i  (nk_val_q),
        .key_o (rom_key),
        .ct_o  (rom_ct)
    );

    assign enc_match  = (data_out == rom_ct);
    assign dec_match  = (data_out == KAT_PT);
    assign accumulate = SWEEP && (nk_val_q != NK4);
    assign last_size  = !SWEEP || (nk_val_q == NK8);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        nk_val_d      = nk_val_q;
        data_in_d     = data_in_q;
        key_in_d      = key_in_q;
        pass_enc_d    = pass_enc_q;
        pass_dec_d    = pass_dec_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    pass_enc_d    = 1'b0;
                    pass_dec_d    = 1'b0;
                    timeout_err_d = 1'b0;
`ifdef AES_KAT_SWEEP_EN
                    nk_val_d = NK4;
                    state_d  = ST_LOAD;
`else
                    nk_val_d = nk_sel;
                    state_d  = (nk_sel == NK_BAD) ? ST_ERR : ST_LOAD;
`endif
                end
            end
            ST_LOAD: begin
                data_in_d = KAT_PT;
                key_in_d  = rom_key;
                state_d   = ST_ENC_REQ;
            end
            ST_ENC_REQ: begin
                cnt_d   = '0;
                state_d = ST_ENC_WAIT;
            end
            ST_ENC_WAIT: begin
                if (done_enc) begin
                    pass_enc_d = enc_match & (accumulate ? pass_enc_q : 1'b1);
                    // Decrypt the reference ciphertext so a bad encrypt cannot hide a bad decrypt.
                    data_in_d  = rom_ct;
                    state_d    = ST_DEC_REQ;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DEC_REQ: begin
                cnt_d   = '0;
                state_d = ST_DEC_WAIT;
            end
            ST_DEC_WAIT: begin
                if (done_dec) begin
                    pass_dec_d = dec_match & (accumulate ? pass_dec_q : 1'b1);
                    state_d    = ST_FINISH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FINISH: begin
                if (last_size) begin
                    state_d = ST_IDLE;
                end else begin
                    nk_val_d = nk_val_q + 2'd1;
                    state_d  = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
            timeout_err_d = 1'b1;
            pass_enc_d    = 1'b0;
            pass_dec_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            nk_val_q      <= '0;
            data_in_q     <= '0;
            key_in_q      <= '0;
            pass_enc_q    <= 1'b0;
            pass_dec_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            nk_val_q      <= nk_val_d;
            data_in_q     <= data_in_d;
            key_in_q      <= key_in_d;
            pass_enc_q    <= pass_enc_d;
            pass_dec_q    <= pass_dec_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign nk_val      = nk_val_q;
    assign data_in     = data_in_q;
    assign key_in      = key_in_q;
    assign start_enc   = (state_q == ST_ENC_REQ);
    assign start_dec   = (state_q == ST_DEC_REQ);
    assign busy        = (state_q != ST_IDLE);
    assign pass_enc    = pass_enc_q;
    assign pass_dec    = pass_dec_q;
    assign timeout_err = timeout_err_q;
    assign done        = ((state_q == ST_FINISH) && last_size) || (state_q == ST_ERR);

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// tb/tb_aes_kat_sequencer.sv - self-checking bench for aes_kat_sequencer with a table-driven AES engine model
`timescale 1ns/1ps
module tb_aes_kat_sequencer;

    localparam int TIMEOUT = 4096;

    logic         clk = 1'b0;
    logic         reset;
    logic         go;
    logic [1:0]   nk_sel;
    logic [1:0]   nk_val;
    logic [127:0] data_in;
    logic [255:0] key_in;
    logic         start_enc, start_dec;
    logic         done_enc, done_dec;
    logic [127:0] data_out;
    logic         busy, pass_enc, pass_dec, done, timeout_err;

    aes_kat_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(13)) dut (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .nk_sel      (nk_sel),
        .nk_val      (nk_val),
        .data_in     (data_in),
        .key_in      (key_in),
        .start_enc   (start_enc),
        .start_dec   (start_dec),
        .done_enc    (done_enc),
        .done_dec    (done_dec),
        .data_out    (data_out),
        .busy        (busy),
        .pass_enc    (pass_enc),
        .pass_dec    (pass_dec),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    logic [127:0] kat_pt = 128'h00112233445566778899aabbccddeeff;
    logic [255:0] kat_key [3] = '{
        {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
        {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f
    };
    logic [127:0] kat_ct [3] = '{
        128'h69c4e0d86a7b0430d8cdb78070b4c55a,
        128'hdda97ca4864cdfe06eaf70a0ec0d7191,
        128'h8ea2b7ca516745bfeafc49904b496089
    };

    // Engine knobs, written by the stimulus block only.
    int eng_lat_e = 1, eng_lat_d = 1;
    bit eng_dec_on = 1'b1;
    int enc_flip_nk = 3, dec_flip_nk = 3;
    int stray_req = 0;

    // Engine-owned state.
    int           stray_ack, enc_cd, dec_cd;
    logic [127:0] enc_res, dec_res, eng_dec_data;
    logic [255:0] eng_enc_key;

    function automatic int nk_of_key(input logic [255:0] k);
        for (int i = 0; i < 3; i++) if (k == kat_key[i]) return i;
        return 3;
    endfunction

    initial begin
        int k;
        done_enc = 1'b0; done_dec = 1'b0; data_out = '0;
        enc_cd = 0; dec_cd = 0; stray_ack = 0;
        eng_dec_data = '0; eng_enc_key = '0; enc_res = '0; dec_res = '0;
        forever begin
            @(posedge clk); #1;
            done_enc = 1'b0; done_dec = 1'b0; data_out = '0;
            if (reset) begin enc_cd = 0; dec_cd = 0; end
            if (enc_cd > 0) begin
                enc_cd--;
                if (enc_cd == 0) begin done_enc = 1'b1; data_out = enc_res; end
            end
            if (dec_cd > 0) begin
                dec_cd--;
                if (dec_cd == 0) begin done_dec = 1'b1; data_out = dec_res; end
            end
            k = nk_of_key(key_in);
            if (start_enc) begin
                enc_res = (k < 3 && data_in == kat_pt) ? kat_ct[k] : ~data_in;
                if (k == enc_flip_nk) enc_res ^= 128'd1;
                eng_enc_key = key_in;
                enc_cd = eng_lat_e;
            end
            if (start_dec && eng_dec_on) begin
                dec_res = (k < 3 && data_in == kat_ct[k]) ? kat_pt : ~data_in;
                if (k == dec_flip_nk) dec_res ^= 128'd1;
                eng_dec_data = data_in;
                dec_cd = eng_lat_d;
            end
            if (stray_req != stray_ack) begin
                stray_ack = stray_req;
                done_dec  = 1'b1;
                data_out  = kat_pt;
            end
        end
    end

    int cyc = 0, n_se = 0, n_sd = 0, n_done = 0, go_cyc = 0, sd_cyc = 0, done_cyc = 0;
    logic [1:0] nk_hist [$];

    always @(negedge clk) begin
        cyc++;
        if (go && !busy) go_cyc = cyc;
        if (start_enc) begin n_se++; nk_hist.push_back(nk_val); end
        if (start_dec) begin n_sd++; sd_cyc = cyc; end
        if (done) begin n_done++; done_cyc = cyc; end
    end

    int checks = 0, errors = 0;

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_vec({tag, " data_in"}, {128'h0, data_in}, 256'h0);
        check_vec({tag, " key_in"}, key_in, 256'h0);
        check_int({tag, " nk_val"}, int'(nk_val), 0);
        check_int({tag, " start_enc"}, int'(start_enc), 0);
        check_int({tag, " start_dec"}, int'(start_dec), 0);
        check_int({tag, " busy"}, int'(busy), 0);
        check_int({tag, " pass_enc"}, int'(pass_enc), 0);
        check_int({tag, " pass_dec"}, int'(pass_dec), 0);
        check_int({tag, " done"}, int'(done), 0);
        check_int({tag, " timeout_err"}, int'(timeout_err), 0);
    endtask

    task automatic run(input logic [1:0] nk, input int budget, input bit extra_go, output bit ok);
        @(posedge clk); #1; nk_sel = nk; go = 1'b1;
        @(posedge clk); #1; go = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #1;
            if (extra_go && i == 4) go = 1'b0;
            if (extra_go && i == 3) begin go = 1'b1; nk_sel = 2'b11; end
            if (done) ok = 1'b1;
        end
        go = 1'b0;
        repeat (3) @(negedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        int s_se, s_sd, s_done, h0, nk, le, ld;
        reset = 1'b1; go = 1'b0; nk_sel = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("por");
        reset = 1'b0;

`ifdef AES_KAT_SWEEP_EN
        eng_lat_e = int'($urandom_range(1, 12));
        eng_lat_d = int'($urandom_range(1, 12));
        s_se = n_se; s_done = n_done; h0 = nk_hist.size();
        run(2'b11, 600, 1'b0, ok);
        check_int("sw done seen", int'(ok), 1);
        check_int("sw start_enc count", n_se - s_se, 3);
        check_int("sw done count", n_done - s_done, 1);
        for (int i = 0; i < 3; i++)
            check_int($sformatf("sw nk_val step%0d", i),
                      (nk_hist.size() > h0 + i) ? int'(nk_hist[h0 + i]) : -1, i);
        check_int("sw pass_enc", int'(pass_enc), 1);
        check_int("sw pass_dec", int'(pass_dec), 1);
        check_int("sw timeout_err", int'(timeout_err), 0);

        enc_flip_nk = 1;
        s_done = n_done;
        run(2'b00, 600, 1'b0, ok);
        check_int("sw2 done seen", int'(ok), 1);
        check_int("sw2 pass_enc", int'(pass_enc), 0);
        check_int("sw2 pass_dec", int'(pass_dec), 1);
        check_int("sw2 done count", n_done - s_done, 1);
        enc_flip_nk = 3;
`else
        // Nk4, 10-cycle engine, with a go (illegal size) while busy that must be ignored.
        eng_lat_e = 10; eng_lat_d = 10;
        s_se = n_se; s_sd = n_sd; s_done = n_done;
        run(2'b00, 200, 1'b1, ok);
        check_int("nk4 done seen", int'(ok), 1);
        check_int("nk4 start_enc count", n_se - s_se, 1);
        check_int("nk4 start_dec count", n_sd - s_sd, 1);
        check_int("nk4 done count", n_done - s_done, 1);
        check_int("nk4 pass_enc", int'(pass_enc), 1);
        check_int("nk4 pass_dec", int'(pass_dec), 1);
        check_int("nk4 timeout_err", int'(timeout_err), 0);
        check_int("nk4 latency", done_cyc - go_cyc, 6 + 9 + 9);
        check_int("nk4 nk_val", int'(nk_val), 0);
        check_int("nk4 busy after", int'(busy), 0);

        // Nk8 with a corrupted encrypt result.
        eng_lat_e = int'($urandom_range(1, 8)); eng_lat_d = int'($urandom_range(1, 8));
        enc_flip_nk = 2;
        run(2'b10, 200, 1'b0, ok);
        check_int("nk8 done seen", int'(ok), 1);
        check_int("nk8 pass_enc", int'(pass_enc), 0);
        check_int("nk8 pass_dec", int'(pass_dec), 1);
        check_vec("nk8 dec data_in", {128'h0, eng_dec_data}, {128'h0, kat_ct[2]});
        check_vec("nk8 key_in", eng_enc_key, kat_key[2]);
        check_int("nk8 timeout_err", int'(timeout_err), 0);
        enc_flip_nk = 3;

        // Nk6 with a silent decrypt.
        eng_dec_on = 1'b0;
        s_done = n_done;
        run(2'b01, TIMEOUT + 200, 1'b0, ok);
        check_int("nk6 done seen", int'(ok), 1);
        check_int("nk6 timeout_err", int'(timeout_err), 1);
        check_int("nk6 timeout latency", done_cyc - sd_cyc, TIMEOUT);
        check_int("nk6 pass_enc", int'(pass_enc), 0);
        check_int("nk6 pass_dec", int'(pass_dec), 0);
        check_int("nk6 done count", n_done - s_done, 1);
        eng_dec_on = 1'b1;

        // Illegal key size.
        s_se = n_se; s_sd = n_sd;
        run(2'b11, 10, 1'b0, ok);
        check_int("bad done seen", int'(ok), 1);
        check_int("bad start_enc count", n_se - s_se, 0);
        check_int("bad start_dec count", n_sd - s_sd, 0);
        check_int("bad timeout_err", int'(timeout_err), 1);
        check_int("bad done within 2", int'((done_cyc - go_cyc) <= 2), 1);
        check_int("bad pass_enc", int'(pass_enc), 0);

        // Reset in ENC_WAIT after a stray done_dec.
        eng_lat_e = 60; eng_lat_d = 1;
        s_sd = n_sd; s_done = n_done;
        @(posedge clk); #1; nk_sel = 2'b00; go = 1'b1;
        @(posedge clk); #1; go = 1'b0;
        repeat (6) @(posedge clk);
        #1; stray_req++;
        repeat (3) @(posedge clk);
        #1;
        check_int("rst busy before", int'(busy), 1);
        check_int("rst stray start_dec", n_sd - s_sd, 0);
        check_int("rst stray pass_dec", int'(pass_dec), 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("mid");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check_int("rst no done", n_done - s_done, 0);

        eng_lat_e = 1; eng_lat_d = 1;
        run(2'b00, 50, 1'b0, ok);
        check_int("post done seen", int'(ok), 1);
        check_int("post latency", done_cyc - go_cyc, 6);
        check_int("post pass_enc", int'(pass_enc), 1);
        check_int("post pass_dec", int'(pass_dec), 1);

        // Randomized runs: latency and flags follow from engine settings alone.
        for (int r = 0; r < 6; r++) begin
            nk = int'($urandom_range(0, 2));
            le = int'($urandom_range(1, 15));
            ld = int'($urandom_range(1, 15));
            eng_lat_e = le; eng_lat_d = ld;
            enc_flip_nk = ($urandom_range(0, 2) == 0) ? nk : 3;
            dec_flip_nk = ($urandom_range(0, 2) == 0) ? nk : 3;
            run(2'(nk), 100, 1'b0, ok);
            check_int($sformatf("rnd%0d done seen", r), int'(ok), 1);
            check_int($sformatf("rnd%0d pass_enc", r), int'(pass_enc), int'(enc_flip_nk != nk));
            check_int($sformatf("rnd%0d pass_dec", r), int'(pass_dec), int'(dec_flip_nk != nk));
            check_int($sformatf("rnd%0d latency", r), done_cyc - go_cyc, 4 + le + ld);
            check_int($sformatf("rnd%0d nk_val", r), int'(nk_val), nk);
        end
        enc_flip_nk = 3; dec_flip_nk = 3;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
